dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data memory between the CPU data port and a loader/debug port. The loader preloads programs and inspects results. The arbiter sits between the CPU's `memwrite`/`dataadr`/`writedata` path and the data memory, and issues a stall to the CPU whenever it loses arbitration. It supports single-beat access plus a bounded loader lock for bursts, with a guaranteed CPU cooldown cycle after a forced release.

## Interface

Parameters:
- `N`, 32, data width.
- `A`, 32, address width.
- `MAX_LOCK`, 8, maximum consecutive loader-exclusive cycles. Must be ≥ 2.

Ports (reset is synchronous and active-high; one clock):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  CPU data access this cycle (load or store).
- `cpu_we`  in  1  CPU store.
- `cpu_adr`  in  A  CPU address.
- `cpu_wd`  in  N  CPU write data.
- `cpu_rd`  out  N  CPU read data.
- `cpu_stall`  out  1  CPU must hold PC and its request.
- `ldr_req`  in  1  loader access this cycle.
- `ldr_we`  in  1  loader store.
- `ldr_lock`  in  1  loader requests exclusive burst.
- `ldr_adr`  in  A  loader address.
- `ldr_wd`  in  N  loader write data.
- `ldr_rd`  out  N  loader read data.
- `ldr_ack`  out  1  loader access performed this cycle.
- `mem_we`  out  1  memory write enable.
- `mem_adr`  out  A  memory address.
- `mem_wd`  out  N  memory write data.
- `mem_rd`  in  N  memory read data (combinational read).

## Operation

States:
- **IDLE**, normal arbitration.
- **LOCKED**, loader exclusive.
- **COOLDOWN**, one cycle with CPU priority.

Registers: state, `rr_last` (last winner), lock counter.

Grant rules:
- IDLE, single requester: that requester is granted.
- IDLE, both requesters: the one that is not `rr_last` is granted.
- LOCKED: only the loader can be granted. `cpu_stall = cpu_req`.
- COOLDOWN: the CPU is granted if `cpu_req`. Otherwise the loader is granted if `ldr_req`.
- `rr_last` updates to the winner on every granted cycle.

Transitions:
- IDLE → LOCKED when the loader is granted with `ldr_lock=1`. Counter loads 1.
- LOCKED → IDLE when `ldr_lock=0`.
- LOCKED → COOLDOWN when the counter reaches `MAX_LOCK`. The counter increments every LOCKED cycle, whether or not `ldr_req` is asserted, so an idle lock still expires.
- COOLDOWN → IDLE always. A lock cannot be entered from COOLDOWN.

Outputs:
- `mem_adr`, `mem_wd` and `mem_we` are driven by the granted port. `mem_we` is the winner's `we`, and 0 when no grant.
- `cpu_rd` and `ldr_rd` both mirror `mem_rd`. They are valid only in the port's granted cycle.
- `cpu_stall = cpu_req & ~cpu_gnt`.
- `ldr_ack = ldr_gnt`.
- During reset: no grants, `mem_we=0`, `ldr_ack=0`, `cpu_stall=cpu_req`.

Reset values: state IDLE, `rr_last`=LDR (so the CPU wins the first contest), counter 0.

## Timing

- Zero-latency: grants are combinational from the registered state plus the current requests.
- A read completes in its granted cycle. A write commits at the rising edge ending its granted cycle.
- A stalled requester holds `req`/`we`/`adr`/`wd` stable until granted. The loader is stalled implicitly: it holds while `ldr_ack=0`.
- Worst-case CPU wait:
  - IDLE contention: 1 cycle with round-robin.
  - Lock: `MAX_LOCK` cycles.
- Reset asserted mid-lock: at the next edge the state is IDLE and the counter is 0. No write issues in the reset cycle.
- Deasserting `ldr_lock` in the last counted cycle: IDLE takes precedence over COOLDOWN.

## Configuration

- `DMEM_ARB_RR_EN` defined: IDLE contention is resolved round-robin via `rr_last`, as described above.
- `DMEM_ARB_RR_EN` undefined: fixed priority. The CPU always wins IDLE contention and `rr_last` is not implemented. LOCKED and COOLDOWN behaviour is unchanged.

## Structure

- `dmem_arb_pkg` holds:
  - `arb_state_t` (IDLE, LOCKED, COOLDOWN);
  - `owner_t` (NONE, CPU, LDR);
  - `MAX_LOCK_DEFAULT`.
- One sub-module, `dmem_arb_lock_timer`:
  - `$clog2(MAX_LOCK+1)`-bit counter with load, increment and clear;
  - `expired` output.
- The top level holds the FSM, the grant logic and the muxes.

## Test plan

- **Reset:** `reset=1` with `cpu_req=1`, `ldr_req=1` → `mem_we=0`, `ldr_ack=0`, `cpu_stall=1`. After release: state IDLE and the first contest goes to the CPU.
- **CPU store:** `cpu_req=1`, `cpu_we=1`, `cpu_adr=84`, `cpu_wd=0x9504` → same cycle `mem_we=1`, `mem_adr=84`, `cpu_stall=0`. Memory word 84 = 0x9504 after the edge.
- **Contention:** both request every cycle. With `DMEM_ARB_RR_EN`, grants go CPU, LDR, CPU, LDR and `cpu_stall` is 0,1,0,1. Without it, the CPU is granted every cycle and `ldr_ack` stays 0.
- **Lock timeout:** `MAX_LOCK=4`, `ldr_lock=1` and `ldr_req=1` held, `cpu_req=1`:
  - `ldr_ack` is 1 for 4 cycles and `cpu_stall` is 1 for those cycles;
  - COOLDOWN follows, with the CPU granted for 1 cycle;
  - then IDLE.
- **Lock release:** drop `ldr_lock` after 2 cycles → next cycle IDLE with normal arbitration. No COOLDOWN cycle.
- **Reset mid-lock, then loader read:** assert reset in LOCKED → state returns to IDLE. A loader read at address 88 then gives `ldr_ack=1` and `ldr_rd = mem_rd` in the same cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM states, port owner, default lock bound.
// Imported by the arbiter, its lock timer and the bus interface users.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    COOLDOWN
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    CPU,
    LDR
  } owner_t;

  localparam int MAX_LOCK_DEFAULT = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between CPU port, loader port and the data memory.
// slave = arbiter view, master = environment (CPU, loader, memory).
interface dmem_arbiter_if #(
  parameter int N = 32,
  parameter int A = 32
);

  logic         cpu_req;
  logic         cpu_we;
  logic [A-1:0] cpu_adr;
  logic [N-1:0] cpu_wd;
  logic [N-1:0] cpu_rd;
  logic         cpu_stall;

  logic         ldr_req;
  logic         ldr_we;
  logic         ldr_lock;
  logic [A-1:0] ldr_adr;
  logic [N-1:0] ldr_wd;
  logic [N-1:0] ldr_rd;
  logic         ldr_ack;

  logic         mem_we;
  logic [A-1:0] mem_adr;
  logic [N-1:0] mem_wd;
  logic [N-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wd,
    input  ldr_req, ldr_we, ldr_lock, ldr_adr, ldr_wd,
    input  mem_rd,
    output cpu_rd, cpu_stall,
    output ldr_rd, ldr_ack,
    output mem_we, mem_adr, mem_wd
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wd,
    output ldr_req, ldr_we, ldr_lock, ldr_adr, ldr_wd,
    output mem_rd,
    input  cpu_rd, cpu_stall,
    input  ldr_rd, ldr_ack,
    input  mem_we, mem_adr, mem_wd
  );

endinterface

// File: rtl/dmem_arb_lock_timer.sv
// Counts loader-exclusive cycles; expired flags the cycle whose
// increment would reach MAX_LOCK, i.e. the last one allowed.
module dmem_arb_lock_timer
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = MAX_LOCK_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam int W = $clog2(MAX_LOCK + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // clear beats load beats increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = W'(1);
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = ((cnt_q + W'(1)) == W'(MAX_LOCK));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between CPU port and loader/debug port.
// DMEM_ARB_RR_EN: round-robin IDLE contention, else CPU fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N        = 32,
  parameter int A        = 32,
  parameter int MAX_LOCK = MAX_LOCK_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);

  arb_state_t   state_q;
  arb_state_t   state_d;
  owner_t       gnt;
  logic         t_load;
  logic         t_inc;
  logic         t_clr;
  logic         expired;
  logic         we_mux;
  logic [A-1:0] adr_mux;
  logic [N-1:0] wd_mux;

`ifdef DMEM_ARB_RR_EN
  owner_t rr_last_q;
  owner_t rr_last_d;
`endif

  dmem_arb_lock_timer #(
    .MAX_LOCK (MAX_LOCK)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (t_load),
    .inc     (t_inc),
    .clr     (t_clr),
    .expired (expired)
  );

  // grant from registered state and live requests
  always_comb begin
    gnt = NONE;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (bus.cpu_req && bus.ldr_req) begin
`ifdef DMEM_ARB_RR_EN
            gnt = (rr_last_q == CPU) ? LDR : CPU;
`else
            gnt = CPU;
`endif
          end else if (bus.cpu_req) begin
            gnt = CPU;
          end else if (bus.ldr_req) begin
            gnt = LDR;
          end
        end
        LOCKED: begin
          if (bus.ldr_req) gnt = LDR;
        end
        COOLDOWN: begin
          if (bus.cpu_req) begin
            gnt = CPU;
          end else if (bus.ldr_req) begin
            gnt = LDR;
          end
        end
        default: gnt = NONE;
      endcase
    end
  end

  // next state; lock release wins over timeout
  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_inc   = 1'b0;
    t_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt == LDR && bus.ldr_lock) begin
          state_d = LOCKED;
          t_load  = 1'b1;
        end
      end
      LOCKED: begin
        t_inc = 1'b1;
        if (!bus.ldr_lock) begin
          state_d = IDLE;
          t_clr   = 1'b1;
        end else if (expired) begin
          state_d = COOLDOWN;
          t_clr   = 1'b1;
        end
      end
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

`ifdef DMEM_ARB_RR_EN
  // remember the last winner
  always_comb begin
    rr_last_d = rr_last_q;
    if (gnt != NONE) rr_last_d = gnt;
  end
`endif

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
`ifdef DMEM_ARB_RR_EN
      rr_last_q <= LDR;
`endif
    end else begin
      state_q   <= state_d;
`ifdef DMEM_ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  // memory-side mux driven by the winner
  always_comb begin
    we_mux  = 1'b0;
    adr_mux = '0;
    wd_mux  = '0;
    unique case (gnt)
      CPU: begin
        we_mux  = bus.cpu_we;
        adr_mux = bus.cpu_adr;
        wd_mux  = bus.cpu_wd;
      end
      LDR: begin
        we_mux  = bus.ldr_we;
        adr_mux = bus.ldr_adr;
        wd_mux  = bus.ldr_wd;
      end
      default: ;
    endcase
  end

  assign bus.mem_we    = we_mux;
  assign bus.mem_adr   = adr_mux;
  assign bus.mem_wd    = wd_mux;
  assign bus.cpu_rd    = bus.mem_rd;
  assign bus.ldr_rd    = bus.mem_rd;
  assign bus.cpu_stall = bus.cpu_req & (gnt != CPU);
  assign bus.ldr_ack   = (gnt == LDR);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + random bench for dmem_arbiter against a cycle-level
// reference model of the arbitration rules and a shadow memory.
module tb_dmem_arbiter;

  localparam int ML = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.N(32), .A(32)) bus ();

  dmem_arbiter #(
    .N        (32),
    .A        (32),
    .MAX_LOCK (ML)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  assign bus.mem_rd = mem[bus.mem_adr[7:0]];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_adr[7:0]] <= bus.mem_wd;
  end

  int checks = 0;
  int errors = 0;

  // model: 0 none, 1 cpu, 2 ldr
  bit m_locked;
  bit m_cool;
  bit m_last_cpu;
  int m_lock_cycles;
  int last_g;
  int acks;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_gnt();
    bit c, l;
    c = bus.cpu_req;
    l = bus.ldr_req;
    if (reset) return 0;
    if (m_locked) return l ? 2 : 0;
    if (m_cool) return c ? 1 : (l ? 2 : 0);
    if (c && l) begin
`ifdef DMEM_ARB_RR_EN
      return m_last_cpu ? 2 : 1;
`else
      return 1;
`endif
    end
    if (c) return 1;
    if (l) return 2;
    return 0;
  endfunction

  task automatic cycle();
    int g;
    logic [31:0] ewe;
    @(negedge clk);
    g = exp_gnt();
    ewe = (g == 1) ? 32'(bus.cpu_we) : (g == 2) ? 32'(bus.ldr_we) : 0;
    chk("mem_we", 32'(bus.mem_we), ewe);
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && g != 1));
    chk("ldr_ack", 32'(bus.ldr_ack), 32'(g == 2));
    if (g == 1) begin
      chk("mem_adr_cpu", bus.mem_adr, bus.cpu_adr);
      if (bus.cpu_we) chk("mem_wd_cpu", bus.mem_wd, bus.cpu_wd);
      else chk("cpu_rd", bus.cpu_rd, ref_mem[bus.cpu_adr[7:0]]);
    end
    if (g == 2) begin
      chk("mem_adr_ldr", bus.mem_adr, bus.ldr_adr);
      if (bus.ldr_we) chk("mem_wd_ldr", bus.mem_wd, bus.ldr_wd);
      else chk("ldr_rd", bus.ldr_rd, ref_mem[bus.ldr_adr[7:0]]);
      acks++;
    end
    @(posedge clk);
    if (g == 1 && bus.cpu_we) ref_mem[bus.cpu_adr[7:0]] = bus.cpu_wd;
    if (g == 2 && bus.ldr_we) ref_mem[bus.ldr_adr[7:0]] = bus.ldr_wd;
    if (reset) begin
      m_locked   = 0;
      m_cool     = 0;
      m_last_cpu = 0;
    end else begin
      if (g != 0) m_last_cpu = (g == 1);
      if (m_locked) begin
        m_lock_cycles++;
        if (!bus.ldr_lock) m_locked = 0;
        else if (m_lock_cycles == ML) begin
          m_locked = 0;
          m_cool   = 1;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (g == 2 && bus.ldr_lock) begin
        m_locked      = 1;
        m_lock_cycles = 1;
      end
    end
    last_g = g;
    #1;
  endtask

  task automatic quiet();
    bus.cpu_req  = 0;
    bus.cpu_we   = 0;
    bus.ldr_req  = 0;
    bus.ldr_we   = 0;
    bus.ldr_lock = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     <= 32'hA5000000 + 32'(i);
      ref_mem[i]  = 32'hA5000000 + 32'(i);
    end
    m_locked = 0; m_cool = 0; m_last_cpu = 0;
    m_lock_cycles = 0; last_g = 0; acks = 0;
    quiet();
    bus.cpu_adr = 32'd4;
    bus.cpu_wd  = 32'h1111;
    bus.ldr_adr = 32'd8;
    bus.ldr_wd  = 32'h2222;

    // reset with both requesting, both writing
    reset = 1;
    bus.cpu_req = 1; bus.cpu_we = 1;
    bus.ldr_req = 1; bus.ldr_we = 1;
    cycle();
    cycle();
    chk("rst_mem4", mem[4], 32'hA5000004);

    // first contest after reset goes to the CPU
    reset = 0;
    bus.cpu_we = 0; bus.ldr_we = 0;
    cycle();
    chk("first_win", 32'(last_g), 32'd1);

    // CPU store
    quiet();
    bus.cpu_req = 1; bus.cpu_we = 1;
    bus.cpu_adr = 32'd84; bus.cpu_wd = 32'h9504;
    cycle();
    chk("mem84", mem[84], 32'h9504);

    // contention, reads
    bus.cpu_we = 0; bus.ldr_req = 1;
    bus.ldr_adr = 32'd84;
    for (int i = 0; i < 4; i++) cycle();

    // lock timeout
    quiet();
    bus.ldr_req = 1; bus.ldr_lock = 1; bus.ldr_we = 1;
    bus.ldr_adr = 32'd100; bus.ldr_wd = 32'hBEEF;
    acks = 0;
    cycle();
    bus.cpu_req = 1; bus.cpu_adr = 32'd100;
    for (int i = 0; i < ML - 1; i++) cycle();
    chk("lock_acks", 32'(acks), 32'(ML));
    cycle();
    chk("cool_gnt", 32'(last_g), 32'd1);
    quiet();
    cycle();

    // lock release after 2 cycles
    bus.ldr_req = 1; bus.ldr_lock = 1; bus.ldr_adr = 32'd12;
    cycle();
    cycle();
    bus.ldr_lock = 0;
    cycle();
    bus.cpu_req = 1; bus.ldr_req = 1;
    cycle();
    cycle();

    // reset mid-lock, then loader read at 88
    quiet();
    bus.ldr_req = 1; bus.ldr_lock = 1; bus.ldr_we = 1;
    bus.ldr_adr = 32'd88; bus.ldr_wd = 32'h7777;
    cycle();
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    quiet();
    bus.ldr_req = 1; bus.ldr_adr = 32'd88;
    cycle();
    chk("ldr88_ack", 32'(last_g), 32'd2);

    // randomized traffic honouring the hold rules
    for (int n = 0; n < 400; n++) begin
      bit hold_c, hold_l;
      hold_c = bus.cpu_req && last_g != 1 && !reset;
      hold_l = bus.ldr_req && last_g != 2 && !reset;
      reset = ($urandom_range(0, 59) == 0);
      if (!hold_c) begin
        bus.cpu_req = ($urandom_range(0, 2) != 0);
        bus.cpu_we  = $urandom_range(0, 1) == 1;
        bus.cpu_adr = 32'($urandom_range(0, 15));
        bus.cpu_wd  = $urandom;
      end
      if (!hold_l) begin
        bus.ldr_req  = ($urandom_range(0, 2) != 0);
        bus.ldr_we   = $urandom_range(0, 1) == 1;
        bus.ldr_adr  = 32'($urandom_range(0, 15));
        bus.ldr_wd   = $urandom;
      end
      bus.ldr_lock = ($urandom_range(0, 3) != 0);
      cycle();
    end

    reset = 0;
    quiet();
    cycle();
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
